tile_pixel_drawer: RTL

//  Consumer end of the tile-address walk. Accepts one tile address per start/done handshake.

---
 rtl/tile_pixel_drawer.sv | 116 +++++++++++
 1 files changed

// File: rtl/tile_pixel_drawer.sv
// Draws one tile per start/done handshake: fetches the tile colour from BRAM, then
// strobes a TILE_W x TILE_W block of pixels at the tile's grid position.
module tile_pixel_drawer #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int TILE_W   = 10,
  parameter int SPACING  = 2,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [8:0]          address,
  output logic                busy,
  output logic                rden,
  output logic [8:0]          rd_address,
  input  logic [COLOUR_W-1:0] rd_data,
  output logic [9:0]          pixelX,
  output logic [8:0]          pixelY,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done
);

  localparam int PITCH = TILE_W + SPACING;
  localparam int TILES = GRID_W * GRID_H;
  localparam int CNT_W = $clog2(TILE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TILE_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] DRAW  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [8:0]       addrLatch;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [9:0]       originX;
  logic [8:0]       originY;

  assign originX = 10'(32'(addrLatch) % GRID_W * PITCH);
  assign originY = 9'(32'(addrLatch) / GRID_W * PITCH);

  // Outputs are set on the transition into the state that owns them, so each
  // one is valid for exactly the cycles that state occupies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addrLatch  <= '0;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      rden       <= 1'b0;
      rd_address <= '0;
      pixelX     <= '0;
      pixelY     <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addrLatch <= address;
            busy      <= 1'b1;
            if ({1'b0, address} >= 10'(TILES)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= READ;
              rden       <= 1'b1;
              rd_address <= address;
            end
          end
        end
        READ: begin
          rden  <= 1'b0;
          state <= LATCH;
        end
        LATCH: begin
          colour <= rd_data;
          col    <= '0;
          row    <= '0;
          pixelX <= originX;
          pixelY <= originY;
          plot   <= 1'b1;
          state  <= DRAW;
        end
        DRAW: begin
          if (col == LAST && row == LAST) begin
            plot  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (col == LAST) begin
            col    <= '0;
            row    <= row + 1'b1;
            pixelX <= originX;
            pixelY <= pixelY + 9'd1;
          end else begin
            col    <= col + 1'b1;
            pixelX <= pixelX + 10'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
